// File: rtl/fib_pkg.sv
// Shared constants and types for the name-tree lookup sequencer.
// The result struct groups what the sequencer reports once a lookup terminates.
package fib_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int POINTER_SIZE = 16;
  localparam int MAX_LEVELS   = 8;
  localparam int LEVEL_BITS   = $clog2(MAX_LEVELS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                    match;
    logic [LEVEL_BITS:0]     depth;
    logic [POINTER_SIZE-1:0] pointer;
  } result_t;

endpackage

// File: rtl/lookup_name_reg.sv
// Holds the name captured at request acceptance and returns the component
// selected by the current tree depth.
module lookup_name_reg
  import fib_pkg::*;
#(
  parameter int WORD_SIZE  = fib_pkg::WORD_SIZE,
  parameter int MAX_LEVELS = fib_pkg::MAX_LEVELS,
  parameter int LEVEL_BITS = fib_pkg::LEVEL_BITS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load_in,
  input  logic [MAX_LEVELS*WORD_SIZE-1:0]  name_in,
  input  logic [LEVEL_BITS-1:0]            sel_in,
  output logic [WORD_SIZE-1:0]             comp_out
);

  logic [WORD_SIZE-1:0] comp_q [MAX_LEVELS];
  logic [WORD_SIZE-1:0] comp_d [MAX_LEVELS];

  always_comb begin
    for (int i = 0; i < MAX_LEVELS; i++) begin
      comp_d[i] = load_in ? name_in[i*WORD_SIZE +: WORD_SIZE] : comp_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEVELS; i++) begin
        comp_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_LEVELS; i++) begin
        comp_q[i] <= comp_d[i];
      end
    end
  end

  // Guard the select for depths that are not a power of two.
  always_comb begin
    comp_out = '0;
    if (32'(sel_in) < MAX_LEVELS) begin
      comp_out = comp_q[sel_in];
    end
  end

endmodule

// File: rtl/lookup_sequencer.sv
// Walks a name tree one level per ISSUE/WAIT pair and reports the longest
// matched prefix together with the child pointer found at the deepest match.
module lookup_sequencer #(
  parameter int WORD_SIZE    = fib_pkg::WORD_SIZE,
  parameter int POINTER_SIZE = fib_pkg::POINTER_SIZE,
  parameter int MAX_LEVELS   = fib_pkg::MAX_LEVELS,
  parameter int LEVEL_BITS   = fib_pkg::LEVEL_BITS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid_in,
  output logic                             req_ready_out,
  input  logic [LEVEL_BITS:0]              name_len_in,
  input  logic [MAX_LEVELS*WORD_SIZE-1:0]  name_in,
  output logic                             level_en_out,
  output logic [LEVEL_BITS-1:0]            level_sel_out,
  output logic [POINTER_SIZE-1:0]          address_out,
  output logic [WORD_SIZE-1:0]             lookup_cont_out,
  input  logic [POINTER_SIZE-1:0]          next_pointer_in,
  input  logic                             is_match_in,
  input  logic                             no_child_in,
  output logic                             result_valid_out,
  input  logic                             result_ready_in,
  output logic                             result_match_out,
  output logic [LEVEL_BITS:0]              result_depth_out,
  output logic [POINTER_SIZE-1:0]          result_pointer_out
);

  import fib_pkg::*;

  localparam logic [LEVEL_BITS:0] MAX_LEN = (LEVEL_BITS+1)'(MAX_LEVELS);

  state_t                  state_q,      state_d;
  logic [LEVEL_BITS:0]     len_q,        len_d;
  logic [LEVEL_BITS-1:0]   depth_q,      depth_d;
  logic [POINTER_SIZE-1:0] cur_ptr_q,    cur_ptr_d;
  logic [LEVEL_BITS:0]     best_depth_q, best_depth_d;
  logic [POINTER_SIZE-1:0] best_ptr_q,   best_ptr_d;
  logic [POINTER_SIZE-1:0] addr_hold_q,  addr_hold_d;
  logic [WORD_SIZE-1:0]    cont_hold_q,  cont_hold_d;

  logic                    name_load;
  logic [WORD_SIZE-1:0]    comp_sel;
  logic [LEVEL_BITS:0]     len_clamped;
  logic [LEVEL_BITS:0]     depth_inc;
  result_t                 result;

  lookup_name_reg #(
    .WORD_SIZE  (WORD_SIZE),
    .MAX_LEVELS (MAX_LEVELS),
    .LEVEL_BITS (LEVEL_BITS)
  ) u_name_reg (
    .clk      (clk),
    .reset    (reset),
    .load_in  (name_load),
    .name_in  (name_in),
    .sel_in   (depth_q),
    .comp_out (comp_sel)
  );

  assign len_clamped = (name_len_in > MAX_LEN) ? MAX_LEN : name_len_in;
  assign depth_inc   = {1'b0, depth_q} + {{LEVEL_BITS{1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    depth_d      = depth_q;
    cur_ptr_d    = cur_ptr_q;
    best_depth_d = best_depth_q;
    best_ptr_d   = best_ptr_q;
    addr_hold_d  = addr_hold_q;
    cont_hold_d  = cont_hold_q;
    name_load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid_in) begin
          name_load    = 1'b1;
          len_d        = len_clamped;
          depth_d      = '0;
          cur_ptr_d    = '0;
          best_depth_d = '0;
          best_ptr_d   = '0;
          state_d      = (len_clamped == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        // Remember what was presented so the level bus holds steady afterwards.
        addr_hold_d = cur_ptr_q;
        cont_hold_d = comp_sel;
        state_d     = WAIT;
      end
      WAIT: begin
        if (is_match_in) begin
          best_depth_d = depth_inc;
          best_ptr_d   = next_pointer_in;
        end
        // Continuing implies depth_inc < len_q <= MAX_LEVELS, so depth cannot wrap.
        if (!is_match_in || no_child_in || (depth_inc == len_q)) begin
          state_d = DONE;
        end else begin
          cur_ptr_d = next_pointer_in;
          depth_d   = depth_inc[LEVEL_BITS-1:0];
          state_d   = ISSUE;
        end
      end
      DONE: begin
        if (result_ready_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      depth_q      <= '0;
      cur_ptr_q    <= '0;
      best_depth_q <= '0;
      best_ptr_q   <= '0;
      addr_hold_q  <= '0;
      cont_hold_q  <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      depth_q      <= depth_d;
      cur_ptr_q    <= cur_ptr_d;
      best_depth_q <= best_depth_d;
      best_ptr_q   <= best_ptr_d;
      addr_hold_q  <= addr_hold_d;
      cont_hold_q  <= cont_hold_d;
    end
  end

  always_comb begin
    result.match   = (best_depth_q != '0);
    result.depth   = best_depth_q;
    result.pointer = best_ptr_q;
  end

  assign req_ready_out      = (state_q == IDLE);
  assign level_en_out       = (state_q == ISSUE);
  assign level_sel_out      = depth_q;
  assign address_out        = (state_q == ISSUE) ? cur_ptr_q : addr_hold_q;
  assign lookup_cont_out    = (state_q == ISSUE) ? comp_sel  : cont_hold_q;
  assign result_valid_out   = (state_q == DONE);
  assign result_match_out   = result.match;
  assign result_depth_out   = result.depth;
  assign result_pointer_out = result.pointer;

endmodule

// File: tb/tb_lookup_sequencer.sv
// Scoreboard bench for lookup_sequencer: a table-driven level model answers
// each ISSUE, and expected results are queued when each request is driven.
module tb_lookup_sequencer;

  localparam int WS = 16;
  localparam int PS = 16;
  localparam int ML = 8;
  localparam int LB = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid_in = 1'b0;
  logic            req_ready_out;
  logic [LB:0]     name_len_in = '0;
  logic [ML*WS-1:0] name_in = '0;
  logic            level_en_out;
  logic [LB-1:0]   level_sel_out;
  logic [PS-1:0]   address_out;
  logic [WS-1:0]   lookup_cont_out;
  logic [PS-1:0]   next_pointer_in = '0;
  logic            is_match_in = 1'b0;
  logic            no_child_in = 1'b0;
  logic            result_valid_out;
  logic            result_ready_in = 1'b0;
  logic            result_match_out;
  logic [LB:0]     result_depth_out;
  logic [PS-1:0]   result_pointer_out;

  lookup_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid_in       (req_valid_in),
    .req_ready_out      (req_ready_out),
    .name_len_in        (name_len_in),
    .name_in            (name_in),
    .level_en_out       (level_en_out),
    .level_sel_out      (level_sel_out),
    .address_out        (address_out),
    .lookup_cont_out    (lookup_cont_out),
    .next_pointer_in    (next_pointer_in),
    .is_match_in        (is_match_in),
    .no_child_in        (no_child_in),
    .result_valid_out   (result_valid_out),
    .result_ready_in    (result_ready_in),
    .result_match_out   (result_match_out),
    .result_depth_out   (result_depth_out),
    .result_pointer_out (result_pointer_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit m;
    int d;
    int p;
    int issues;
    int lat;
  } exp_t;

  exp_t         sb[$];
  logic [15:0]  t_name [8];
  bit           t_match[8];
  logic [15:0]  t_ptr  [8];
  bit           t_nc   [8];
  int           issue_cnt  = 0;
  int           exp_issues = 0;
  logic [15:0]  last_addr  = '0;

  // Level model: answers each ISSUE so the response is present during WAIT.
  always @(negedge clk) begin
    int lvl;
    if (!reset && level_en_out) begin
      lvl = issue_cnt;
      check_eq("issue_bound", 32'(lvl < exp_issues), 32'd1);
      if (lvl < 8) begin
        check_eq("level_sel", 32'(level_sel_out), 32'(lvl));
        check_eq("address", 32'(address_out), (lvl == 0) ? 32'd0 : 32'(t_ptr[lvl-1]));
        check_eq("cont", 32'(lookup_cont_out), 32'(t_name[lvl]));
        is_match_in     = t_match[lvl];
        next_pointer_in = t_ptr[lvl];
        no_child_in     = t_nc[lvl];
      end
      last_addr = address_out;
      issue_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_lookup(input int len_raw, input int hold);
    exp_t e;
    int   l;
    int   lat;
    bit   timed_out;
    l = (len_raw > 8) ? 8 : len_raw;
    e.m = 0; e.d = 0; e.p = 0; e.issues = 0;
    for (int d = 0; d < l; d++) begin
      e.issues++;
      if (t_match[d]) begin
        e.m = 1;
        e.d = d + 1;
        e.p = int'(t_ptr[d]);
      end
      if (!t_match[d] || t_nc[d] || (d + 1 == l)) break;
    end
    e.lat = (e.issues == 0) ? 1 : 2 * e.issues + 1;
    sb.push_back(e);
    exp_issues = e.issues;
    issue_cnt  = 0;

    check_eq("req_ready", 32'(req_ready_out), 32'd1);
    for (int i = 0; i < 8; i++) name_in[i*16 +: 16] = t_name[i];
    name_len_in  = 4'(len_raw);
    req_valid_in = 1'b1;
    @(posedge clk);
    #1 req_valid_in = 1'b0;

    lat = 0;
    timed_out = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (result_valid_out) break;
      if (!level_en_out && issue_cnt > 0)
        check_eq("addr_hold", 32'(address_out), 32'(last_addr));
      if (lat >= 60) begin
        timed_out = 1;
        break;
      end
    end
    e = sb.pop_front();
    if (timed_out) begin
      check_eq("timeout", 32'd0, 32'd1);
      do_reset();
      return;
    end

    $display("lookup len=%0d: match=%0d depth=%0d ptr=%04h lat=%0d issues=%0d",
             len_raw, result_match_out, result_depth_out, result_pointer_out, lat, issue_cnt);
    check_eq("res_match", 32'(result_match_out), 32'(e.m));
    check_eq("res_depth", 32'(result_depth_out), 32'(e.d));
    check_eq("res_ptr", 32'(result_pointer_out), 32'(e.p));
    check_eq("latency", 32'(lat), 32'(e.lat));
    check_eq("issues", 32'(issue_cnt), 32'(e.issues));

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(result_valid_out), 32'd1);
      check_eq("bp_depth", 32'(result_depth_out), 32'(e.d));
      check_eq("bp_ptr", 32'(result_pointer_out), 32'(e.p));
      check_eq("bp_ready", 32'(req_ready_out), 32'd0);
    end

    check_eq("no_accept", 32'(req_ready_out), 32'd0);
    result_ready_in = 1'b1;
    @(posedge clk);
    #1 result_ready_in = 1'b0;
    @(negedge clk);
    check_eq("ready_after", 32'(req_ready_out), 32'd1);
    check_eq("valid_after", 32'(result_valid_out), 32'd0);
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 8; i++) begin
      t_name[i]  = 16'h0;
      t_match[i] = 1'b0;
      t_ptr[i]   = 16'h0;
      t_nc[i]    = 1'b0;
    end
  endtask

  initial begin
    clear_tables();
    do_reset();

    check_eq("rst_ready", 32'(req_ready_out), 32'd1);
    check_eq("rst_valid", 32'(result_valid_out), 32'd0);
    check_eq("rst_level_en", 32'(level_en_out), 32'd0);
    check_eq("rst_addr", 32'(address_out), 32'd0);
    check_eq("rst_cont", 32'(lookup_cont_out), 32'd0);
    check_eq("rst_depth", 32'(result_depth_out), 32'd0);
    check_eq("rst_ptr", 32'(result_pointer_out), 32'd0);
    check_eq("rst_match", 32'(result_match_out), 32'd0);

    // Single-level hit on a leaf.
    clear_tables();
    t_name[0] = 16'h7b7d; t_match[0] = 1; t_ptr[0] = 16'h0001; t_nc[0] = 1;
    run_lookup(1, 0);

    // Two-level walk.
    clear_tables();
    t_name[0] = 16'h7b7d; t_match[0] = 1; t_ptr[0] = 16'h0001; t_nc[0] = 0;
    t_name[1] = 16'h2121; t_match[1] = 1; t_ptr[1] = 16'h0005; t_nc[1] = 0;
    run_lookup(2, 0);

    // Partial prefix: second level misses, with backpressure.
    clear_tables();
    t_name[0] = 16'h1111; t_match[0] = 1; t_ptr[0] = 16'h0001;
    t_name[1] = 16'h2222; t_match[1] = 0; t_ptr[1] = 16'h0bad;
    t_name[2] = 16'h3333; t_match[2] = 1; t_ptr[2] = 16'h0777;
    run_lookup(3, 5);

    // Zero-length name.
    clear_tables();
    t_match[0] = 1; t_ptr[0] = 16'h0042;
    run_lookup(0, 0);

    // Over-long length clamps to a full 8-level walk.
    clear_tables();
    for (int i = 0; i < 8; i++) begin
      t_name[i] = 16'hA000 + 16'(i); t_match[i] = 1; t_ptr[i] = 16'h0010 + 16'(i);
    end
    run_lookup(12, 1);

    // Miss at level 1 after a previous hit: result must not carry stale state.
    clear_tables();
    t_name[0] = 16'h5555; t_match[0] = 0; t_ptr[0] = 16'h0099;
    run_lookup(4, 0);

    // Leaf reached before the name ends.
    clear_tables();
    for (int i = 0; i < 5; i++) begin
      t_name[i] = 16'hC000 + 16'(i); t_match[i] = 1; t_ptr[i] = 16'h0100 + 16'(i);
    end
    t_nc[2] = 1;
    run_lookup(5, 2);

    // Reset during WAIT abandons the lookup.
    clear_tables();
    for (int i = 0; i < 3; i++) begin
      t_name[i] = 16'hD000 + 16'(i); t_match[i] = 1; t_ptr[i] = 16'h0200 + 16'(i);
    end
    exp_issues = 3;
    issue_cnt  = 0;
    for (int i = 0; i < 8; i++) name_in[i*16 +: 16] = t_name[i];
    name_len_in  = 4'd3;
    req_valid_in = 1'b1;
    @(posedge clk);
    #1 req_valid_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (level_en_out) break;
    end
    check_eq("reset_seen_issue", 32'(level_en_out), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    $display("mid-lookup reset: ready=%0d valid=%0d", req_ready_out, result_valid_out);
    check_eq("mid_rst_ready", 32'(req_ready_out), 32'd1);
    check_eq("mid_rst_valid", 32'(result_valid_out), 32'd0);
    check_eq("mid_rst_level_en", 32'(level_en_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("mid_rst_no_result", 32'(result_valid_out), 32'd0);
    end

    // Normal operation resumes after the abandoned lookup.
    clear_tables();
    t_name[0] = 16'h0a0a; t_match[0] = 1; t_ptr[0] = 16'h0033;
    t_name[1] = 16'h0b0b; t_match[1] = 1; t_ptr[1] = 16'h0044;
    run_lookup(2, 0);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 8; i++) begin
        t_name[i]  = 16'($urandom);
        t_match[i] = ($urandom_range(0, 3) != 0);
        t_ptr[i]   = 16'($urandom);
        t_nc[i]    = ($urandom_range(0, 4) == 0);
      end
      run_lookup(int'($urandom_range(0, 12)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
